// File: rtl/mem_stage.sv
// MEM stage: latches EX->MEM, waits on data_ok, aligns load data, drives WB/RF buses.
// Optional MEM_ADDR_CHK_EN flags misaligned accesses on mem_excp.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 142,
  parameter int MEM_TO_WB_WD = 136,
  parameter int STALL_WD     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [4:0]              ex_load_op,
  input  logic [31:0]             data_sram_rdata,
  input  logic                    data_ok,
  output logic                    stallreq_for_mem,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [103:0]            mem_to_rf_bus,
  output logic                    mem_excp
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  logic [EX_TO_MEM_WD-1:0] r_bus;
  logic [4:0]              r_op;
  logic [31:0]             r_buf;
  state_t                  r_state;
  state_t                  w_nxt;

  logic        w_load;
  logic        w_bub;
  logic        w_adv;
  logic        w_in_excp;
  logic        w_excp;
  logic        w_in_en;
  logic        w_cap;
  logic        w_pend;
  logic        w_we;
  logic [1:0]  w_a;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_src;
  logic [31:0] w_ld;
  logic [31:0] w_wdata;
  logic        w_unused;

`ifdef MEM_ADDR_CHK_EN
  function automatic logic misal(
    input logic       en,
    input logic [1:0] a,
    input logic [3:0] wen,
    input logic       sel,
    input logic [4:0] op
  );
    logic half;
    logic word;
    half = op[2] | op[1] | (wen == 4'b0011) | (wen == 4'b1100);
    word = op[0] | (wen == 4'b1111) | (sel & (op == 5'b0));
    return en & ((half & a[0]) | (word & (a != 2'b00)));
  endfunction

  assign w_in_excp = misal(ex_to_mem_bus[43], ex_to_mem_bus[1:0],
                           ex_to_mem_bus[42:39], ex_to_mem_bus[38],
                           ex_load_op);
  assign w_excp = misal(r_bus[43], r_bus[1:0], r_bus[42:39],
                        r_bus[38], r_op);
`else
  assign w_in_excp = 1'b0;
  assign w_excp    = 1'b0;
`endif

  assign w_load  = ~stall[3];
  assign w_bub   = stall[3] & ~stall[4];
  assign w_adv   = w_load | w_bub;
  assign w_in_en = w_load & ex_to_mem_bus[43] & ~w_in_excp;

  always_comb begin
    w_nxt = r_state;
    w_cap = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_adv) w_nxt = w_in_en ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (data_ok) begin
          if (w_adv) begin
            w_nxt = w_in_en ? S_WAIT : S_IDLE;
          end else begin
            w_nxt = S_DONE;
            w_cap = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (w_adv) w_nxt = w_in_en ? S_WAIT : S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_bus   <= '0;
      r_op    <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_cap) r_buf <= data_sram_rdata;
      if (w_load) begin
        r_bus <= ex_to_mem_bus;
        r_op  <= ex_load_op;
      end else if (w_bub) begin
        r_bus <= '0;
        r_op  <= '0;
      end
    end
  end

  // A response still owed holds rf_we low so nothing stale is forwarded.
  assign w_pend = (r_state == S_WAIT) & ~data_ok;
  assign w_src  = ((r_state == S_WAIT) & data_ok) ? data_sram_rdata : r_buf;
  assign w_a    = r_bus[1:0];
  assign w_half = w_a[1] ? w_src[31:16] : w_src[15:0];

  always_comb begin
    w_byte = w_src[7:0];
    unique case (w_a)
      2'd0:    w_byte = w_src[7:0];
      2'd1:    w_byte = w_src[15:8];
      2'd2:    w_byte = w_src[23:16];
      default: w_byte = w_src[31:24];
    endcase
  end

  always_comb begin
    w_ld = w_src;
    unique case (1'b1)
      r_op[4]: w_ld = {{24{w_byte[7]}}, w_byte};
      r_op[3]: w_ld = {24'h0, w_byte};
      r_op[2]: w_ld = {{16{w_half[15]}}, w_half};
      r_op[1]: w_ld = {16'h0, w_half};
      default: w_ld = w_src;
    endcase
  end

  assign w_wdata = r_bus[38] ? w_ld : r_bus[31:0];
  assign w_we    = r_bus[37] & ~w_pend & ~w_excp;

  assign stallreq_for_mem = w_pend;
  assign mem_excp         = w_excp;

  assign mem_to_wb_bus = {r_bus[141:76], r_bus[75:44], w_we,
                          r_bus[36:32], w_wdata};
  assign mem_to_rf_bus = {r_bus[141:76], w_we, r_bus[36:32], w_wdata};

  assign w_unused = ^{stall[5], stall[2:0], r_bus[42:39]};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scoreboard of expected WB/RF results.
module tb_mem_stage;

  localparam logic [4:0] LB  = 5'b10000;
  localparam logic [4:0] LBU = 5'b01000;
  localparam logic [4:0] LH  = 5'b00100;
  localparam logic [4:0] LHU = 5'b00010;
  localparam logic [4:0] LW  = 5'b00001;
  localparam logic [5:0] HLD = 6'b011111;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [5:0]   stall;
  logic [141:0] ex_bus;
  logic [4:0]   ld_op;
  logic [31:0]  rdata;
  logic         data_ok;
  logic         stallreq;
  logic [135:0] wb_bus;
  logic [103:0] rf_bus;
  logic         excp;

  int nchk = 0;
  int nerr = 0;
  logic [135:0] sbq[$];

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .ex_to_mem_bus    (ex_bus),
    .ex_load_op       (ld_op),
    .data_sram_rdata  (rdata),
    .data_ok          (data_ok),
    .stallreq_for_mem (stallreq),
    .mem_to_wb_bus    (wb_bus),
    .mem_to_rf_bus    (rf_bus),
    .mem_excp         (excp)
  );

  always #5 clk = ~clk;

  function automatic logic [141:0] mk(
    input logic [31:0] pc,
    input logic        en,
    input logic [3:0]  wen,
    input logic        sel,
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] res
  );
    return {2'b01, 32'h0, pc, pc, en, wen, sel, we, wa, res};
  endfunction

  function automatic logic [135:0] wbx(
    input logic [141:0] b,
    input logic         we,
    input logic [31:0]  wd
  );
    return {b[141:76], b[75:44], we, b[36:32], wd};
  endfunction

  task automatic chk(input string tag, input logic [135:0] got,
                     input logic [135:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_wb(input string tag);
    logic [135:0] e;
    nchk++;
    assert (sbq.size() != 0) else begin
      nerr++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk({tag, "_wb"}, wb_bus, e);
      chk({tag, "_rf"}, {32'h0, rf_bus}, {32'h0, e[135:70], e[37:0]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seq(input logic [141:0] b, input logic [4:0] op,
                          input logic [31:0] rd, input int nw,
                          input logic [31:0] exp, input string tag);
    ex_bus  = b;
    ld_op   = op;
    stall   = 6'b0;
    data_ok = 1'b0;
    sbq.push_back(wbx(b, 1'b1, exp));
    tick();
    ex_bus = '0;
    ld_op  = '0;
    for (int i = 0; i < nw; i++) begin
      stall   = HLD;
      data_ok = 1'b0;
      rdata   = $urandom;
      #3;
      chk({tag, "_stall"}, stallreq, 1'b1);
      chk({tag, "_wb_we"}, wb_bus[37], 1'b0);
      chk({tag, "_rf_we"}, rf_bus[37], 1'b0);
      tick();
    end
    stall   = 6'b0;
    data_ok = 1'b1;
    rdata   = rd;
    #3;
    chk({tag, "_nostall"}, stallreq, 1'b0);
    chk({tag, "_excp"}, excp, 1'b0);
    chk_wb(tag);
    tick();
    data_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [141:0] b;
    logic [141:0] b2;
    stall   = 6'b0;
    ex_bus  = '0;
    ld_op   = '0;
    rdata   = '0;
    data_ok = 1'b0;
    rst     = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    chk("rst_wb", wb_bus, '0);
    chk("rst_rf", {32'h0, rf_bus}, '0);
    chk("rst_stall", stallreq, 1'b0);
    chk("rst_excp", excp, 1'b0);
    rst = 1'b1;
    tick();

    // reset while an access is outstanding
    ex_bus = mk(32'h1000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3, 32'h100);
    ld_op  = LW;
    tick();
    ex_bus = '0;
    ld_op  = '0;
    stall  = HLD;
    #3;
    chk("t1_wait", stallreq, 1'b1);
    rst = 1'b0;
    #1;
    chk("t1_rst_wb", wb_bus, '0);
    chk("t1_rst_stall", stallreq, 1'b0);
    tick();
    rst     = 1'b1;
    stall   = 6'b0;
    data_ok = 1'b1;
    rdata   = 32'h5555_5555;
    #3;
    chk("t1_late_stall", stallreq, 1'b0);
    chk("t1_late_we", wb_bus[37], 1'b0);
    tick();
    data_ok = 1'b0;
    #3;
    chk("t1_after", wb_bus, '0);
    tick();

    // lw with data_ok in the entry cycle
    b = mk(32'h2000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd5, 32'h100);
    load_seq(b, LW, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, "t2_lw");

    // byte/half extension with varied latency
    b = mk(32'h3000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 32'h103);
    load_seq(b, LB, 32'h80A1_B2C3, 3, 32'hFFFF_FF80, "t3_lb");
    b = mk(32'h3004, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 32'h103);
    load_seq(b, LBU, 32'h80A1_B2C3, 1, 32'h0000_0080, "t3_lbu");
    b = mk(32'h3008, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h100);
    load_seq(b, LHU, 32'h1234_F00F, 0, 32'h0000_F00F, "t3_lhu");
    b = mk(32'h300C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4, 32'h300);
    load_seq(b, 5'b0, 32'hCAFE_F00D, 2, 32'hCAFE_F00D, "t3_dflt");

    // response arrives while the register is held: buffered in DONE
    b = mk(32'h4000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h202);
    ex_bus = b;
    ld_op  = LH;
    sbq.push_back(wbx(b, 1'b1, 32'hFFFF_8001));
    tick();
    ex_bus  = '0;
    ld_op   = '0;
    stall   = HLD;
    data_ok = 1'b1;
    rdata   = 32'h8001_1234;
    #3;
    chk("t4_entry_stall", stallreq, 1'b0);
    chk("t4_entry_data", wb_bus[31:0], 32'hFFFF_8001);
    tick();
    data_ok = 1'b0;
    rdata   = 32'h0;
    #3;
    chk("t4_done_stall", stallreq, 1'b0);
    chk("t4_buf_data", wb_bus[31:0], 32'hFFFF_8001);
    chk("t4_buf_we", rf_bus[37], 1'b1);
    tick();
    stall = 6'b0;
    #3;
    chk_wb("t4_lh");
    tick();

    // back-to-back sw then lw
    b  = mk(32'h5000, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h200);
    b2 = mk(32'h5004, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h204);
    ex_bus = b;
    ld_op  = 5'b0;
    sbq.push_back(wbx(b, 1'b0, 32'h200));
    tick();
    ex_bus = '0;
    stall  = HLD;
    #3;
    chk("t5_sw_stall", stallreq, 1'b1);
    tick();
    stall   = 6'b0;
    data_ok = 1'b1;
    rdata   = 32'h7777_7777;
    ex_bus  = b2;
    ld_op   = LW;
    #3;
    chk("t5_sw_go", stallreq, 1'b0);
    chk_wb("t5_sw");
    sbq.push_back(wbx(b2, 1'b1, 32'h1234_5678));
    tick();
    ex_bus  = '0;
    ld_op   = '0;
    data_ok = 1'b0;
    stall   = HLD;
    #3;
    chk("t5_lw_stall", stallreq, 1'b1);
    chk("t5_lw_we", wb_bus[37], 1'b0);
    tick();
    stall   = 6'b0;
    data_ok = 1'b1;
    rdata   = 32'h1234_5678;
    #3;
    chk("t5_lw_go", stallreq, 1'b0);
    chk_wb("t5_lw");
    tick();
    data_ok = 1'b0;

    // misaligned word access
    b = mk(32'h7000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd11, 32'h102);
`ifdef MEM_ADDR_CHK_EN
    ex_bus = b;
    ld_op  = LW;
    tick();
    ex_bus = '0;
    ld_op  = '0;
    #3;
    chk("t6_excp", excp, 1'b1);
    chk("t6_we", wb_bus[37], 1'b0);
    chk("t6_rf_we", rf_bus[37], 1'b0);
    chk("t6_stall", stallreq, 1'b0);
    tick();
    #3;
    chk("t6_clear", excp, 1'b0);
`else
    load_seq(b, LW, 32'h0BAD_F00D, 1, 32'h0BAD_F00D, "t6_lw");
`endif

    // non-access ALU result passes straight through
    b = mk(32'h6000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd10, 32'h0000_ABCD);
    ex_bus = b;
    ld_op  = 5'b0;
    sbq.push_back(wbx(b, 1'b1, 32'h0000_ABCD));
    tick();
    ex_bus = '0;
    #3;
    chk("t7_stall", stallreq, 1'b0);
    chk_wb("t7_alu");
    tick();

    chk("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
